// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD command arbiter: command width,
// command field positions and the arbiter state encoding.
package lcd_pkg;

    localparam int LCD_CMD_W = 10;
    localparam int RS_BIT    = 9;
    localparam int RW_BIT    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } lcd_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// reports the first set request bit.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter sharing one LCD controller between N_REQ command sources;
// latches the winner's command and runs the enable/busy handshake.
module lcd_cmd_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*LCD_CMD_W-1:0] req_cmd,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           err,
    output logic                       lcd_enable,
    output logic [LCD_CMD_W-1:0]       lcd_bus,
    input  logic                       lcd_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    lcd_arb_state_t state, state_d;
    logic [IW-1:0]        ptr, ptr_d;
    logic [7:0]           tcnt, tcnt_d;
    logic [IW-1:0]        grant_d;
    logic [LCD_CMD_W-1:0] bus_d;
    logic [N_REQ-1:0]     ack_d, err_d;
    logic                 enable_d, active_d;

    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [LCD_CMD_W-1:0] cmds [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cmds[i] = req_cmd[i*LCD_CMD_W +: LCD_CMD_W];
        end
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(N_REQ - 1);
            tcnt       <= '0;
            grant_id   <= '0;
            lcd_bus    <= '0;
            lcd_enable <= 1'b0;
            ack        <= '0;
            err        <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            tcnt       <= tcnt_d;
            grant_id   <= grant_d;
            lcd_bus    <= bus_d;
            lcd_enable <= enable_d;
            ack        <= ack_d;
            err        <= err_d;
            active     <= active_d;
        end
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        tcnt_d  = tcnt;
        grant_d = grant_id;
        bus_d   = lcd_bus;
        ack_d   = '0;
        err_d   = '0;
        case (state)
            IDLE: begin
                if (!lcd_busy && pick_valid) begin
                    state_d = ISSUE;
                    ptr_d   = pick_idx;
                    grant_d = pick_idx;
                    bus_d   = cmds[pick_idx];
                    tcnt_d  = '0;
                end
            end
            ISSUE: begin
                tcnt_d = tcnt + 8'd1;
                // Busy wins over the timeout when both land on the same cycle.
                if (lcd_busy) begin
                    state_d         = WAIT_DONE;
                    ack_d[grant_id] = 1'b1;
                end else if (tcnt == TLIM) begin
                    state_d         = IDLE;
                    err_d[grant_id] = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        enable_d = (state_d == ISSUE);
        active_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter with a behavioural LCD controller and an
// ack/err scoreboard.
module tb_lcd_cmd_arbiter;

    localparam int N = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*10-1:0] req_cmd = '0;
    logic [N-1:0]  ack, err;
    logic          lcd_enable;
    logic [9:0]    lcd_bus;
    logic          lcd_busy;
    logic [1:0]    grant_id;
    logic          active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       is_err;
        int       id;
        logic [9:0] bus;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Controller model: registers enable, raises busy after accept_delay enable cycles.
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   never_accept = 1'b0;
    int   accept_delay = 1;
    int   busy_len = 51;
    int   en_cnt = 0;
    int   busy_left = 0;

    assign lcd_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    lcd_cmd_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_cmd    (req_cmd),
        .ack        (ack),
        .err        (err),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .lcd_busy   (lcd_busy),
        .grant_id   (grant_id),
        .active     (active)
    );

    always @(posedge clk) begin
        if (busy_left > 0) begin
            busy_left  <= busy_left - 1;
            model_busy <= (busy_left > 1);
        end else if (lcd_enable && !never_accept) begin
            if (en_cnt + 1 >= accept_delay) begin
                model_busy <= 1'b1;
                busy_left  <= busy_len;
                en_cnt     <= 0;
            end else begin
                en_cnt <= en_cnt + 1;
            end
        end else begin
            en_cnt     <= 0;
            model_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_err, input int id, input logic [9:0] bus);
        exp_t e;
        e.is_err = is_err;
        e.id     = id;
        e.bus    = bus;
        sb.push_back(e);
    endtask

    task automatic set_cmd(input int i, input logic [9:0] v);
        req_cmd[i*10 +: 10] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!active && !lcd_busy) break;
        end
        chk(tag, 32'(active), 32'd0);
    endtask

    task automatic wait_pulse(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack != '0 || err != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic count_enable(output int n, input int bound);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (lcd_enable) n++;
            else if (n > 0) break;
        end
    endtask

    // Scoreboard: every ack/err pulse must match the oldest expected outcome.
    always @(negedge clk) begin
        if (!rst && (ack != '0 || err != '0)) begin
            chk("onehot", 32'($onehot(ack | err)), 32'd1);
            if (sb.size() == 0) begin
                chk("sb_unexpected", {24'd0, 4'(ack), 4'(err)}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_ack", 32'(ack), mon_e.is_err ? 32'd0 : (32'd1 << mon_e.id));
                chk("sb_err", 32'(err), mon_e.is_err ? (32'd1 << mon_e.id) : 32'd0);
                chk("sb_bus", 32'(lcd_bus), 32'(mon_e.bus));
                chk("sb_gid", 32'(grant_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        int n;
        int acks;
        int en_seen;

        // Reset state
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_enable", 32'(lcd_enable), 32'd0);
        chk("rst_bus", 32'(lcd_bus), 32'd0);
        chk("rst_ackerr", {24'd0, 4'(ack), 4'(err)}, 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);

        // Controller busy after reset blocks the first grant
        rst = 1'b0;
        req = 4'b0001;
        set_cmd(0, 10'h2A5);
        en_seen = 0;
        for (int i = 0; i < 440; i++) begin
            @(negedge clk);
            if (lcd_enable || active) en_seen++;
        end
        chk("init_busy_block", 32'(en_seen), 32'd0);
        force_busy = 1'b0;
        push(1'b0, 0, 10'h2A5);
        @(negedge clk);
        chk("c1_enable", 32'(lcd_enable), 32'd1);
        chk("c1_bus", 32'(lcd_bus), 32'h2A5);
        chk("c1_active", 32'(active), 32'd1);
        @(negedge clk);
        chk("c2_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("c3_ack0", 32'(ack), 32'b0001);
        chk("c3_enable", 32'(lcd_enable), 32'd0);
        req = '0;
        wait_idle("s1_idle", 200);

        // All four requesting: round-robin order 0,1,2,3,0
        do_reset();
        set_cmd(0, 10'h101);
        set_cmd(1, 10'h0F2);
        set_cmd(2, 10'h3C3);
        set_cmd(3, 10'h204);
        push(1'b0, 0, 10'h101);
        push(1'b0, 1, 10'h0F2);
        push(1'b0, 2, 10'h3C3);
        push(1'b0, 3, 10'h204);
        push(1'b0, 0, 10'h101);
        req = 4'b1111;
        acks = 0;
        for (int i = 0; i < 600 && acks < 5; i++) begin
            @(negedge clk);
            if (ack != '0) acks++;
        end
        req = '0;
        chk("rr_ack_count", 32'(acks), 32'd5);
        wait_idle("s2_idle", 200);

        // Controller never accepts: timeout after TO enable cycles
        do_reset();
        never_accept = 1'b1;
        set_cmd(2, 10'h1E7);
        push(1'b1, 2, 10'h1E7);
        req = 4'b0100;
        count_enable(n, 100);
        req = '0;
        chk("to_enable_len", 32'(n), 32'(TO));
        chk("to_err", 32'(err), 32'b0100);
        chk("to_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'd0);
        chk("to_idle", 32'(active), 32'd0);
        never_accept = 1'b0;

        // Request withdrawn and command changed right after grant
        do_reset();
        set_cmd(2, 10'h155);
        push(1'b0, 2, 10'h155);
        req = 4'b0100;
        @(negedge clk);
        chk("wd_enable", 32'(lcd_enable), 32'd1);
        req = '0;
        set_cmd(2, 10'h2AA);
        @(negedge clk);
        chk("wd_bus_hold", 32'(lcd_bus), 32'h155);
        @(negedge clk);
        chk("wd_ack2", 32'(ack), 32'b0100);
        wait_idle("s4_idle", 200);

        // Reset during WAIT_DONE; next grant waits for the controller
        busy_len = 30;
        set_cmd(0, 10'h0C8);
        push(1'b0, 0, 10'h0C8);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("wd_state_busy", {30'd0, active, lcd_busy}, 32'd3);
        set_cmd(1, 10'h3F0);
        req = 4'b0010;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {20'd0, lcd_bus, lcd_enable, active}, 32'd0);
        chk("mid_rst_pulses", {22'd0, 4'(ack), 4'(err), 2'(grant_id)}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 100 && lcd_busy; i++) begin
            @(negedge clk);
            if (lcd_busy && lcd_enable) en_seen++;
        end
        chk("post_rst_block", 32'(en_seen), 32'd0);
        push(1'b0, 1, 10'h3F0);
        wait_pulse("post_rst_ack", 20);
        req = '0;
        wait_idle("s5_idle", 200);

        // Busy rises on the last allowed ISSUE cycle: accepted, not timed out
        do_reset();
        accept_delay = TO - 1;
        busy_len = 3;
        set_cmd(3, 10'h36C);
        push(1'b0, 3, 10'h36C);
        req = 4'b1000;
        count_enable(n, 100);
        req = '0;
        chk("edge_enable_len", 32'(n), 32'(TO));
        chk("edge_ack3", 32'(ack), 32'b1000);
        chk("edge_no_err", 32'(err), 32'd0);
        wait_idle("s6_idle", 50);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
